// File: rtl/fetch_prefetch_queue.sv
// Decoupled instruction prefetch queue: sequential imem reads, PC-tagged FIFO, redirect flush.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0100_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        set_PC,
  input  logic [31:0] new_PC,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_misaligned
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  entry_t         mem [DEPTH];
  entry_t         shown_q;
  logic [PW-1:0]  head, tail;
  logic [CW-1:0]  occupancy, outstanding, drop_count, in_flight;
  logic [31:0]    fetch_pc, rsp_pc, redirect_pc;
  logic           halted;
  logic           rsp_accept, rsp_drop, push, pop, issue;

  assign rsp_accept = imem_rsp_valid && (outstanding != '0);
  assign rsp_drop   = drop_count != '0;
  assign push       = rsp_accept && !rsp_drop && !set_PC && !reset;
  assign pop        = instr_valid && instr_ready && !set_PC;
  assign issue      = imem_req_valid && imem_req_ready;
  // Requests still owed by imem once this cycle's response (if any) is consumed.
  assign in_flight  = outstanding - CW'(rsp_accept);

  // Slots are reserved at issue time, so every response always finds room.
  assign imem_req_valid = !reset && !set_PC && !halted &&
                          ((occupancy + outstanding) < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc;

  assign instr_valid = occupancy != '0;
  assign instr       = instr_valid ? mem[head].data : shown_q.data;
  assign instr_pc    = instr_valid ? mem[head].pc   : shown_q.pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned_q;

  always_ff @(posedge clock) begin
    if (reset)       misaligned_q <= 1'b0;
    else if (set_PC) misaligned_q <= new_PC[1:0] != 2'b00;
  end

  assign halted      = misaligned_q;
  assign redirect_pc = new_PC;
`else
  assign halted      = 1'b0;
  assign redirect_pc = new_PC & ~32'h3;
`endif
  assign fetch_misaligned = halted;

  // NOTE: the storage array has no reset; only the pointers/occupancy define validity.
  always_ff @(posedge clock) begin
    if (push) mem[tail] <= '{data: imem_rsp_data, pc: rsp_pc};
  end

  // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      occupancy   <= '0;
      head        <= '0;
      tail        <= '0;
      // Reads already sent to imem still come back; keep counting them and drop them all.
      outstanding <= in_flight;
      drop_count  <= in_flight;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      shown_q     <= '0;
    end else begin
      shown_q     <= '{data: instr, pc: instr_pc};
      outstanding <= in_flight + CW'(issue);
      if (set_PC) begin
        occupancy  <= '0;
        head       <= '0;
        tail       <= '0;
        drop_count <= in_flight;
        fetch_pc   <= redirect_pc;
        rsp_pc     <= redirect_pc;
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_accept) begin
          if (rsp_drop) drop_count <= drop_count - CW'(1);
          else          rsp_pc     <= rsp_pc + 32'd4;
        end
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
        occupancy <= occupancy + CW'(push) - CW'(pop);
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    assert (!(imem_rsp_valid && outstanding == '0))
      else $error("imem response with no outstanding request");
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: queue-based reference model plus directed cases.
// Define FETCH_MISALIGN_CHECK_EN for both files to exercise the misaligned-redirect trap.
module tb_fetch_prefetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0100_0000;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clock, reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        set_PC;
  logic [31:0] new_PC;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        fetch_misaligned;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .set_PC(set_PC), .new_PC(new_PC),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .fetch_misaligned(fetch_misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // In-flight read: address, cycle its response is due, and whether a flush orphaned it.
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;
  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  req_t        inflight[$];
  ent_t        fifo_m[$];
  logic [31:0] m_fetch_pc, shown_data, shown_pc;
  bit          m_halted;
  int          cyc, last_due, lat_min, lat_max, dut_issues;
  int          checks, errors;

  bit          d_reset, d_set, d_ready, d_req_ready;
  logic [31:0] d_new;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, advance the model.
  task automatic step();
    bit          rsp, exp_req, exp_iv;
    logic [31:0] exp_data, exp_pc;
    req_t        r;
    int          due;
    @(negedge clock);
    reset          = d_reset;
    set_PC         = d_set;
    new_PC         = d_new;
    instr_ready    = d_ready;
    imem_req_ready = d_req_ready;
    rsp            = inflight.size() > 0 && inflight[0].due <= cyc;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(inflight[0].addr) : $urandom;
    #1;
    exp_req  = !d_reset && !d_set && !m_halted && (fifo_m.size() + inflight.size() < DEPTH);
    exp_iv   = fifo_m.size() > 0;
    exp_data = exp_iv ? fifo_m[0].data : shown_data;
    exp_pc   = exp_iv ? fifo_m[0].pc   : shown_pc;
    check("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) check("req_addr", imem_req_addr, m_fetch_pc);
    check("instr_valid", 32'(instr_valid), 32'(exp_iv));
    check("instr", instr, exp_data);
    check("instr_pc", instr_pc, exp_pc);
    check("misaligned", 32'(fetch_misaligned), 32'(m_halted));
    if (imem_req_valid && imem_req_ready) dut_issues++;

    if (rsp) r = inflight.pop_front();
    if (d_reset || d_set) begin
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      fifo_m.delete();
      if (d_reset) begin
        m_fetch_pc = RESET_PC;
        m_halted   = 1'b0;
        shown_data = '0;
        shown_pc   = '0;
      end else begin
        m_halted   = MIS_EN && (d_new[1:0] != 2'b00);
        m_fetch_pc = MIS_EN ? d_new : (d_new & ~32'h3);
        shown_data = exp_data;
        shown_pc   = exp_pc;
      end
    end else begin
      shown_data = exp_data;
      shown_pc   = exp_pc;
      if (exp_iv && d_ready) void'(fifo_m.pop_front());
      if (rsp && !r.stale) fifo_m.push_back('{data: mem_word(r.addr), pc: r.addr});
      if (exp_req && d_req_ready) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        inflight.push_back('{addr: m_fetch_pc, due: due, stale: 1'b0});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until instr_valid is seen (bounded), then pin the PC presented.
  task automatic wait_first_pc(input string name, input logic [31:0] exp_pc);
    bit found = 1'b0;
    for (int i = 0; i < 25 && !found; i++) begin
      step();
      found = instr_valid;
    end
    check({name, "_seen"}, 32'(found), 32'd1);
    if (found) check(name, instr_pc, exp_pc);
  endtask

  task automatic redirect(input logic [31:0] pc);
    d_set = 1'b1;
    d_new = pc;
    step();
    d_set = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pcs[3];
    int          n_pc, base;
    checks = 0; errors = 0; cyc = 0; last_due = 0; dut_issues = 0;
    m_fetch_pc = RESET_PC; m_halted = 1'b0; shown_data = '0; shown_pc = '0;
    lat_min = 1; lat_max = 1;
    d_reset = 1'b1; d_set = 1'b0; d_new = '0; d_ready = 1'b1; d_req_ready = 1'b1;
    run(3);
    check("reset_instr_pc", instr_pc, 32'h0);

    // Sequential fetch, latency 1: first valid instruction two cycles after the first request.
    d_reset = 1'b0;
    step();
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_req_addr, 32'h0100_0000);
    step();
    check("cycle1_instr_valid", 32'(instr_valid), 32'd0);
    step();
    check("cycle2_instr_valid", 32'(instr_valid), 32'd1);
    check("cycle2_instr_pc", instr_pc, 32'h0100_0000);
    check("cycle2_instr", instr, mem_word(32'h0100_0000));
    step();
    check("cycle3_instr_pc", instr_pc, 32'h0100_0004);
    run(4);

    // Decode stalled: exactly DEPTH requests go out, then issue stops until pops free slots.
    d_reset = 1'b1;
    run(2);
    d_reset = 1'b0; d_ready = 1'b0;
    base = dut_issues;
    run(10);
    check("stall_issue_count", 32'(dut_issues - base), 32'(DEPTH));
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    d_ready = 1'b1;
    run(20);

    // Latency 3, redirect with two requests in flight: both stale responses are dropped.
    lat_min = 3; lat_max = 3;
    d_reset = 1'b1;
    run(4);
    d_reset = 1'b0;
    run(2);
    redirect(32'h0100_0100);
    wait_first_pc("redirect_lat3_pc", 32'h0100_0100);

    // Redirect coinciding with a pop and a response in steady streaming.
    lat_min = 1; lat_max = 1;
    run(8);
    redirect(32'h0100_0400);
    check("pre_redirect_valid", 32'(instr_valid), 32'd1);
    step();
    check("post_redirect_valid", 32'(instr_valid), 32'd0);
    wait_first_pc("redirect_pop_pc", 32'h0100_0400);

    // Address wrap at the top of the address space.
    redirect(32'hFFFF_FFF8);
    n_pc = 0;
    for (int i = 0; i < 30 && n_pc < 3; i++) begin
      step();
      if (instr_valid) begin
        pcs[n_pc] = instr_pc;
        n_pc++;
      end
    end
    check("wrap_count", 32'(n_pc), 32'd3);
    check("wrap_pc0", pcs[0], 32'hFFFF_FFF8);
    check("wrap_pc1", pcs[1], 32'hFFFF_FFFC);
    check("wrap_pc2", pcs[2], 32'h0000_0000);

    // Misaligned redirect target.
    redirect(32'h0100_0102);
    step();
`ifdef FETCH_MISALIGN_CHECK_EN
    check("misaligned_set", 32'(fetch_misaligned), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("halted_no_req", 32'(imem_req_valid), 32'd0);
    end
    redirect(32'h0100_0200);
    check("misaligned_clear", 32'(fetch_misaligned), 32'd0);
    wait_first_pc("resume_pc", 32'h0100_0200);
`else
    check("misaligned_tied", 32'(fetch_misaligned), 32'd0);
    wait_first_pc("aligned_down_pc", 32'h0100_0100);
`endif

    // Randomized traffic with occasional redirects and resets.
    for (int blk = 0; blk < 15; blk++) begin
      int rdy_pct, req_pct;
      lat_min = $urandom_range(2, 1);
      lat_max = lat_min + $urandom_range(3, 0);
      rdy_pct = $urandom_range(100, 20);
      req_pct = $urandom_range(100, 30);
      for (int i = 0; i < 200; i++) begin
        d_reset     = $urandom_range(999) < 4;
        d_set       = $urandom_range(99) < 3;
        d_ready     = $urandom_range(99) < rdy_pct;
        d_req_ready = $urandom_range(99) < req_pct;
        case ($urandom_range(7))
          0:       d_new = 32'hFFFF_FFF0 + {$urandom_range(3), 2'b00};
          1:       d_new = $urandom;
          default: d_new = {$urandom_range(32'h3FFF_FFFF), 2'b00};
        endcase
        step();
      end
    end
    d_reset = 1'b0; d_set = 1'b0; d_ready = 1'b1; d_req_ready = 1'b1;
    run(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
